mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 op  input  6  instruction opcode, IR[31:26], held stable by datapath.
REQ-005 funct  input  6  R-type function field, IR[5:0].
REQ-006 zero  input  1  ALU zero flag from the ALU stage.
REQ-007 alucontrol  output  4  ALU operation: add 0010, sub 0110, and 0000, or 0001, slt 0111, sll 1000.
REQ-008 pcen  output  1  PC register write enable.
REQ-009 memwrite, irwrite, regwrite  output  1 each  memory / IR / register-file write enables.
REQ-010 iord, alusrca, regdst, memtoreg  output  1 each  datapath mux selects.
REQ-011 alusrcb  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-012 pcsrc  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-013 state  output  4  current FSM state, debug/verification.

Function
REQ-014 Moore FSM; all outputs decoded from registered state (plus zero for pcen, funct for alucontrol/regwrite) with no extra latency.
REQ-015 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11; codes 12-15 go to FETCH next cycle with all enables 0.
REQ-016 Defaults in every state: all enables 0, all selects 0, alucontrol 0010, unless listed below.
REQ-017 FETCH: irwrite=1, pcwrite=1, alusrcb=01, add -> DECODE.
REQ-018 DECODE: alusrcb=11, add; next by op: 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 001000 -> ADDIEX, 000010 -> JEX, any other -> FETCH (no architectural write).
REQ-019 MEMADR: alusrca=1, alusrcb=10, add; op 100011 -> MEMRD, else -> MEMWR.
REQ-020 MEMRD: iord=1 -> MEMWB; MEMWB: memtoreg=1, regwrite=1 -> FETCH.
REQ-021 MEMWR: iord=1, memwrite=1 -> FETCH.
REQ-022 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll; unknown funct -> 0010 -> RTYPEWB.
REQ-023 RTYPEWB: regdst=1, regwrite=1 only if funct is one of the six decoded values, else regwrite=0 -> FETCH.
REQ-024 BEQEX: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01 -> FETCH.
REQ-025 ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB; ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-026 JEX: pcwrite=1, pcsrc=10 -> FETCH.
REQ-027 pcen = pcwrite | (branch & zero); zero ignored outside BEQEX.
REQ-028 Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, undefined op 2.

Reset
REQ-029 reset=0 at a rising edge forces state=FETCH, overriding any transition, including mid-instruction (aborts it; no write enable asserted by the aborted instruction after that edge).
REQ-030 While reset held low, state stays FETCH; first instruction fetch occurs on the first rising edge with reset=1.
REQ-031 No storage other than the 4-bit state register.

Verification
REQ-032 lw (op 100011): reset release -> states 0,1,2,3,4,0; regwrite=1 & memtoreg=1 only in state 4; iord=1 in 3.
REQ-033 R-type funct 101010 -> alucontrol=0111 in state 6, regdst=1 & regwrite=1 in state 7; funct 000000 -> 1000; funct 111111 -> regwrite=0 in 7.
REQ-034 beq with zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=0110; same with zero=0 -> pcen=0; zero=1 in DECODE -> pcen=0.
REQ-035 op 111111 -> states 0,1,0; no memwrite/regwrite asserted; j (000010) -> pcen=1, pcsrc=10 in state 11.
REQ-036 sw: reset=0 asserted during MEMADR -> next state 0, memwrite never asserted; reset held 3 cycles -> state stays 0, then normal fetch.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alucontrol;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output alucontrol, pcen, memwrite, irwrite, regwrite, iord,
               alusrca, regdst, memtoreg, alusrcb, pcsrc, state
    );

    modport slave (
        output op, funct, zero,
        input  alucontrol, pcen, memwrite, irwrite, regwrite, iord,
               alusrca, regdst, memtoreg, alusrcb, pcsrc, state
    );
endinterface

// File: rtl/mc_controller.sv
// Moore FSM controller for a multicycle MIPS-subset datapath.
// Only storage is the 4-bit state register; everything else decodes from it.
module mc_controller (
    input  logic             clk,
    input  logic             reset,
    mc_controller_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    state_t     st, st_nx;
    logic       pcwrite, branch;
    logic       funct_ok;
    logic [3:0] funct_alu;

    always_ff @(posedge clk) begin
        if (!reset) st <= FETCH;
        else        st <= st_nx;
    end

    // R-type function decode; unknown functs fall back to add and suppress writeback.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            6'b000000: funct_alu = ALU_SLL;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        st_nx          = FETCH;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        bus.alucontrol = ALU_ADD;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.alusrca    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        case (st)
            FETCH: begin
                bus.irwrite = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
                st_nx       = DECODE;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    6'b100011, 6'b101011: st_nx = MEMADR;
                    6'b000000:            st_nx = RTYPEEX;
                    6'b000100:            st_nx = BEQEX;
                    6'b001000:            st_nx = ADDIEX;
                    6'b000010:            st_nx = JEX;
                    default:              st_nx = FETCH;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                st_nx       = (bus.op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.iord = 1'b1;
                st_nx    = MEMWB;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            RTYPEEX: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = funct_alu;
                st_nx          = RTYPEWB;
            end
            RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = funct_ok;
            end
            BEQEX: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = ALU_SUB;
                branch         = 1'b1;
                bus.pcsrc      = 2'b01;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                st_nx       = ADDIWB;
            end
            ADDIWB: bus.regwrite = 1'b1;
            JEX: begin
                pcwrite   = 1'b1;
                bus.pcsrc = 2'b10;
            end
            default: st_nx = FETCH;
        endcase
    end

    assign bus.pcen  = pcwrite | (branch & bus.zero);
    assign bus.state = st;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction table, reset corner cases and random
// instruction streams, checked against an instruction-level reference model.
module tb_mc_controller;
    logic clk;
    logic reset;
    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        int         zmode;   // 0/1 fixed zero, 2 random each cycle
        int         cpi;
    } vec_t;

    // Output bundle: {memwrite,irwrite,regwrite,iord,alusrca,regdst,memtoreg,pcen,alusrcb,pcsrc,alucontrol}
    function automatic logic [15:0] dut_out();
        return {bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.alusrca,
                bus.regdst, bus.memtoreg, bus.pcen, bus.alusrcb, bus.pcsrc, bus.alucontrol};
    endfunction

    function automatic logic [3:0] funct_op(input logic [5:0] f, output logic known);
        known = 1'b1;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b000000: return 4'b1000;
            default: begin known = 1'b0; return 4'b0010; end
        endcase
    endfunction

    // Expected control word for a given step of an instruction.
    function automatic logic [15:0] model_out(input int s, input logic [5:0] f, input logic z);
        logic mw = 0, ir = 0, rw = 0, iord = 0, sa = 0, rd = 0, mtr = 0, pcen = 0, known;
        logic [1:0] sb = 0, ps = 0;
        logic [3:0] alu = 4'b0010;
        case (s)
            0:  begin ir = 1; pcen = 1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  iord = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; alu = funct_op(f, known); end
            7:  begin rd = 1; void'(funct_op(f, known)); rw = known; end
            8:  begin sa = 1; alu = 4'b0110; ps = 2'b01; pcen = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin pcen = 1; ps = 2'b10; end
            default: ;
        endcase
        return {mw, ir, rw, iord, sa, rd, mtr, pcen, sb, ps, alu};
    endfunction

    function automatic void path_of(input logic [5:0] op, output int p[$]);
        case (op)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000000: p = '{0, 1, 6, 7};
            6'b000100: p = '{0, 1, 8};
            6'b001000: p = '{0, 1, 9, 10};
            6'b000010: p = '{0, 1, 11};
            default:   p = '{0, 1};
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a falling edge; one iteration per clock.
    task automatic run_instr(input vec_t v);
        int p[$];
        logic z;
        path_of(v.op, p);
        for (int c = 0; c < v.cpi; c++) begin
            z = (v.zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(v.zmode);
            bus.op = v.op; bus.funct = v.funct; bus.zero = z;
            #1;
            check({v.name, " state"}, {12'd0, bus.state}, {12'd0, (c < p.size()) ? 4'(p[c]) : 4'hF});
            check({v.name, " ctrl"}, dut_out(), model_out((c < p.size()) ? p[c] : 15, v.funct, z));
            @(negedge clk);
        end
        #1;
        check({v.name, " cpi"}, {12'd0, bus.state}, 16'd0);
        @(negedge clk);
        // put us back on a falling edge with the FETCH cycle unconsumed
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        tbl.push_back('{"lw",      6'b100011, 6'b000000, 2, 5});
        tbl.push_back('{"sw",      6'b101011, 6'b111000, 2, 4});
        tbl.push_back('{"add",     6'b000000, 6'b100000, 2, 4});
        tbl.push_back('{"sub",     6'b000000, 6'b100010, 2, 4});
        tbl.push_back('{"and",     6'b000000, 6'b100100, 2, 4});
        tbl.push_back('{"or",      6'b000000, 6'b100101, 2, 4});
        tbl.push_back('{"slt",     6'b000000, 6'b101010, 2, 4});
        tbl.push_back('{"sll",     6'b000000, 6'b000000, 2, 4});
        tbl.push_back('{"rbad",    6'b000000, 6'b111111, 2, 4});
        tbl.push_back('{"beq_z1",  6'b000100, 6'b000000, 1, 3});
        tbl.push_back('{"beq_z0",  6'b000100, 6'b000000, 0, 3});
        tbl.push_back('{"addi",    6'b001000, 6'b101010, 1, 4});
        tbl.push_back('{"j",       6'b000010, 6'b000000, 1, 3});
        tbl.push_back('{"undef",   6'b111111, 6'b100000, 1, 2});
        tbl.push_back('{"undef1",  6'b000001, 6'b000000, 2, 2});

        reset = 1'b0; bus.op = 6'b100011; bus.funct = 0; bus.zero = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", {12'd0, bus.state}, 16'd0);
        check("reset ctrl", dut_out(), model_out(0, 6'd0, 1'b1));
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) run_instr(tbl[i]);

        // sw aborted by reset during MEMADR, reset held for three edges
        for (int c = 0; c < 3; c++) begin
            bus.op = 6'b101011; bus.funct = 0; bus.zero = 1'b0;
            if (c == 2) reset = 1'b0;
            #1;
            check("sw_abort pre", {12'd0, bus.state}, {12'd0, 4'(c)});
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            check("sw_abort state", {12'd0, bus.state}, 16'd0);
            check("sw_abort ctrl", dut_out(), model_out(0, 6'd0, 1'b0));
            @(negedge clk);
        end
        reset = 1'b1;
        run_instr(tbl[0]);

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            int p[$];
            v.name  = "rand";
            v.op    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            v.funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            v.zmode = 2;
            path_of(v.op, p);
            v.cpi = p.size();
            run_instr(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
